// File: rtl/ultrasonic_pkg.sv
// Shared definitions for the ultrasonic transmit path: scheduler states and
// the default carrier/burst/slot timing also used by the single-channel design.
package ultrasonic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BURST  = 2'd1,
        LISTEN = 2'd2
    } tx_state_e;

    localparam int unsigned DEF_CARRIER_DIV  = 32'd1024;
    localparam int unsigned DEF_BURST_PULSES = 32'd32;
    localparam int unsigned DEF_SLOT_PERIODS = 32'd575;

endpackage

// File: rtl/rr_next_channel.sv
// Combinational round-robin finder: next set bit of mask above current,
// wrapping through index 0 and finally back to current itself.
module rr_next_channel #(
    parameter int unsigned NUM_CH = 32'd4
) (
    input  logic [NUM_CH-1:0]         mask,
    input  logic [$clog2(NUM_CH)-1:0] current,
    output logic [$clog2(NUM_CH)-1:0] next_id,
    output logic                      found
);
    localparam int unsigned IW = $clog2(NUM_CH);

    // Scan farthest-first so the nearest set bit above current wins.
    always_comb begin
        next_id = current;
        for (int k = int'(NUM_CH); k >= 1; k--) begin
            next_id = mask[(int'(current) + k) % int'(NUM_CH)]
                    ? IW'((int'(current) + k) % int'(NUM_CH))
                    : next_id;
        end
        found = |mask;
    end

endmodule

// File: rtl/ultrasonic_tx_scheduler.sv
// Time-division scheduler: one transmitter at a time fires a carrier burst and
// then listens, rotating round-robin over the channels enabled in TX_MASK.
module ultrasonic_tx_scheduler
    import ultrasonic_pkg::*;
#(
    parameter int unsigned NUM_TX       = 32'd4,
    parameter int unsigned CARRIER_DIV  = DEF_CARRIER_DIV,
    parameter int unsigned BURST_PULSES = DEF_BURST_PULSES,
    parameter int unsigned SLOT_PERIODS = DEF_SLOT_PERIODS
) (
    input  logic                      CLK_40,
    input  logic                      RST,
    input  logic                      ENABLE,
    input  logic [NUM_TX-1:0]         TX_MASK,
    output logic [2*NUM_TX-1:0]       PULSE_OUT,
    output logic                      BURST_START,
    output logic [$clog2(NUM_TX)-1:0] ACTIVE_ID,
    output logic                      SLOT_VALID,
    output logic                      FRAME_START
);
    localparam int unsigned CW = $clog2(CARRIER_DIV);
    localparam int unsigned PW = $clog2(SLOT_PERIODS);
    localparam int unsigned IW = $clog2(NUM_TX);
    localparam logic [CW-1:0] CAR_LAST   = CW'(CARRIER_DIV - 32'd1);
    localparam logic [CW-1:0] CAR_HALF   = CW'(CARRIER_DIV / 32'd2);
    localparam logic [PW-1:0] BURST_LAST = PW'(BURST_PULSES - 32'd1);
    localparam logic [PW-1:0] SLOT_LAST  = PW'(SLOT_PERIODS - 32'd1);
    localparam logic [IW-1:0] ID_TOP     = IW'(NUM_TX - 32'd1);

    if (((CARRIER_DIV & (CARRIER_DIV - 32'd1)) != 32'd0) || (CARRIER_DIV < 32'd4)) begin : g_bad_div
        $error("CARRIER_DIV must be a power of two and at least 4");
    end
    if (BURST_PULSES >= SLOT_PERIODS) begin : g_bad_slot
        $error("BURST_PULSES must be smaller than SLOT_PERIODS");
    end

    tx_state_e           state_r, state_s;
    logic [CW-1:0]       car_cnt_r;
    logic [PW-1:0]       per_cnt_r, per_cnt_s;
    logic [IW-1:0]       active_id_r, active_id_s;
    logic                frame_r, frame_s;
    logic [IW-1:0]       rr_cur_s, rr_id_s;
    logic                rr_found_s;
    logic                car_last_s, burst_first_s;
    logic [NUM_TX-1:0]   fire_s;
    logic [2*NUM_TX-1:0] pulse_next_s;
    logic [2*NUM_TX-1:0] pulse_out_r;
    logic                burst_start_r, slot_valid_r, frame_start_r;
    logic [IW-1:0]       active_id_out_r;

    // From IDLE, searching "after the top channel" yields the lowest set bit.
    assign rr_cur_s      = (state_r == IDLE) ? ID_TOP : active_id_r;
    assign car_last_s    = (car_cnt_r == CAR_LAST);
    assign burst_first_s = (state_r == BURST) && (car_cnt_r == {CW{1'b0}}) && (per_cnt_r == {PW{1'b0}});

    rr_next_channel #(.NUM_CH(NUM_TX)) u_rr (
        .mask    (TX_MASK),
        .current (rr_cur_s),
        .next_id (rr_id_s),
        .found   (rr_found_s)
    );

    // Slot sequencing: a burst always runs to completion, listening can be cut short.
    always_comb begin
        state_s     = state_r;
        per_cnt_s   = per_cnt_r;
        active_id_s = active_id_r;
        frame_s     = frame_r;
        case (state_r)
            IDLE: begin
                per_cnt_s = {PW{1'b0}};
                if (car_last_s && ENABLE && rr_found_s) begin
                    state_s     = BURST;
                    active_id_s = rr_id_s;
                    frame_s     = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            BURST: begin
                if (car_last_s && (per_cnt_r == BURST_LAST)) begin
                    state_s   = ENABLE ? LISTEN : IDLE;
                    per_cnt_s = ENABLE ? (per_cnt_r + PW'(1)) : {PW{1'b0}};
                end else if (car_last_s) begin
                    per_cnt_s = per_cnt_r + PW'(1);
                end else begin
                    per_cnt_s = per_cnt_r;
                end
            end
            LISTEN: begin
                if (!ENABLE) begin
                    state_s   = IDLE;
                    per_cnt_s = {PW{1'b0}};
                end else if (car_last_s && (per_cnt_r == SLOT_LAST)) begin
                    per_cnt_s = {PW{1'b0}};
                    if (rr_found_s) begin
                        state_s     = BURST;
                        active_id_s = rr_id_s;
                        frame_s     = (rr_id_s <= active_id_r);
                    end else begin
                        state_s = IDLE;
                    end
                end else if (car_last_s) begin
                    per_cnt_s = per_cnt_r + PW'(1);
                end else begin
                    per_cnt_s = per_cnt_r;
                end
            end
            default: begin
                state_s   = IDLE;
                per_cnt_s = {PW{1'b0}};
            end
        endcase
    end

    // Drive level per channel: high half of each carrier period of the owner's burst.
    always_comb begin
        fire_s       = {NUM_TX{1'b0}};
        pulse_next_s = {NUM_TX{2'b10}};
        for (int i = 0; i < int'(NUM_TX); i++) begin
            fire_s[i] = (state_r == BURST) && (active_id_r == IW'(i)) && (car_cnt_r >= CAR_HALF);
            pulse_next_s[2*i +: 2] = {~fire_s[i], fire_s[i]};
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK_40) begin
        if (RST) begin
            state_r         <= IDLE;
            car_cnt_r       <= {CW{1'b0}};
            per_cnt_r       <= {PW{1'b0}};
            active_id_r     <= {IW{1'b0}};
            frame_r         <= 1'b0;
            pulse_out_r     <= {NUM_TX{2'b10}};
            burst_start_r   <= 1'b0;
            slot_valid_r    <= 1'b0;
            frame_start_r   <= 1'b0;
            active_id_out_r <= {IW{1'b0}};
        end else begin
            state_r         <= state_s;
            car_cnt_r       <= car_cnt_r + CW'(1);
            per_cnt_r       <= per_cnt_s;
            active_id_r     <= active_id_s;
            frame_r         <= frame_s;
            pulse_out_r     <= pulse_next_s;
            burst_start_r   <= burst_first_s;
            slot_valid_r    <= (state_r != IDLE);
            frame_start_r   <= burst_first_s && frame_r;
            active_id_out_r <= active_id_r;
        end
    end

    assign PULSE_OUT   = pulse_out_r;
    assign BURST_START = burst_start_r;
    assign ACTIVE_ID   = active_id_out_r;
    assign SLOT_VALID  = slot_valid_r;
    assign FRAME_START = frame_start_r;

endmodule

// File: tb/tb_ultrasonic_tx_scheduler.sv
// Bench for ultrasonic_tx_scheduler: directed scenarios plus random mask/enable
// traffic, checked every cycle against a slot-timeline reference model.
module tb_ultrasonic_tx_scheduler;
    localparam int DIV = 8;
    localparam int BP  = 2;
    localparam int SP  = 5;

    logic       CLK_40 = 1'b0;
    logic       RST = 1'b1;
    logic       en = 1'b0;
    logic [3:0] mask = 4'b0000;
    logic [7:0] PULSE_OUT;
    logic       BURST_START, SLOT_VALID, FRAME_START;
    logic [1:0] ACTIVE_ID;

    int checks = 0;
    int failures = 0;

    // Reference model: where we are on the slot timeline, in whole cycles.
    int   n, t0, ch_m;
    bit   in_slot, frame_m;
    logic [7:0] exp_po;
    logic exp_bs, exp_fs, exp_sv;
    logic [1:0] exp_id;

    int bs_ids[$];
    int bs_cyc[$];
    int fs_cyc[$];
    int hi_cnt[4];
    int sv_cnt;

    ultrasonic_tx_scheduler #(
        .NUM_TX(4), .CARRIER_DIV(DIV), .BURST_PULSES(BP), .SLOT_PERIODS(SP)
    ) dut (
        .CLK_40(CLK_40), .RST(RST), .ENABLE(en), .TX_MASK(mask),
        .PULSE_OUT(PULSE_OUT), .BURST_START(BURST_START), .ACTIVE_ID(ACTIVE_ID),
        .SLOT_VALID(SLOT_VALID), .FRAME_START(FRAME_START)
    );

    always #5 CLK_40 = ~CLK_40;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest_ch(logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic int next_ch(int cur, logic [3:0] m);
        for (int k = 1; k <= 4; k++) if (m[(cur + k) % 4]) return (cur + k) % 4;
        return cur;
    endfunction

    // Expected outputs for cycle n+1 from the model at cycle n, then advance.
    task automatic model_eval();
        int off, nx;
        off    = n - t0;
        exp_bs = in_slot && (off == 0);
        exp_fs = exp_bs && frame_m;
        exp_sv = in_slot;
        exp_id = 2'(ch_m);
        exp_po = 8'hAA;
        if (in_slot && off < BP*DIV && (n % DIV) >= DIV/2) exp_po[2*ch_m +: 2] = 2'b01;
        if (!in_slot) begin
            if ((n % DIV) == DIV-1 && en && mask != 4'b0000) begin
                in_slot = 1'b1; t0 = n + 1; ch_m = lowest_ch(mask); frame_m = 1'b1;
            end
        end else if (off == BP*DIV - 1) begin
            if (!en) in_slot = 1'b0;
        end else if (off >= BP*DIV) begin
            if (!en) in_slot = 1'b0;
            else if (off == SP*DIV - 1) begin
                if (mask == 4'b0000) in_slot = 1'b0;
                else begin
                    nx = next_ch(ch_m, mask);
                    frame_m = (nx <= ch_m);
                    ch_m = nx;
                    t0 = n + 1;
                end
            end
        end
        n++;
    endtask

    task automatic step();
        model_eval();
        @(posedge CLK_40); #1;
        check("pulse_out", PULSE_OUT, exp_po);
        check("burst_start", BURST_START, exp_bs);
        check("frame_start", FRAME_START, exp_fs);
        check("slot_valid", SLOT_VALID, exp_sv);
        check("active_id", ACTIVE_ID, exp_id);
        if (BURST_START === 1'b1) begin bs_ids.push_back(int'(ACTIVE_ID)); bs_cyc.push_back(n); end
        if (FRAME_START === 1'b1) fs_cyc.push_back(n);
        for (int i = 0; i < 4; i++) if (PULSE_OUT[2*i +: 2] === 2'b01) hi_cnt[i]++;
        if (SLOT_VALID === 1'b1) sv_cnt++;
    endtask

    task automatic clear_stats();
        bs_ids.delete(); bs_cyc.delete(); fs_cyc.delete();
        for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
        sv_cnt = 0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(posedge CLK_40); #1;
        check("rst_pulse_out", PULSE_OUT, 8'hAA);
        check("rst_burst_start", BURST_START, 1'b0);
        check("rst_frame_start", FRAME_START, 1'b0);
        check("rst_slot_valid", SLOT_VALID, 1'b0);
        check("rst_active_id", ACTIVE_ID, 2'd0);
        RST = 1'b0;
        n = 0; t0 = 0; ch_m = 0; in_slot = 1'b0; frame_m = 1'b0;
        clear_stats();
    endtask

    task automatic run_to_offset(input int target, input int limit, input string tag);
        int waited = 0;
        while (!(in_slot && (n - t0) == target) && waited < limit) begin step(); waited++; end
        check(tag, (in_slot && (n - t0) == target), 1);
    endtask

    task automatic run_to_starts(input int k, input int limit, input string tag);
        int waited = 0;
        while (bs_ids.size() < k && waited < limit) begin step(); waited++; end
        check(tag, bs_ids.size() >= k, 1);
    endtask

    initial begin
        repeat (2) @(posedge CLK_40);
        #1;
        do_reset();

        // Full mask, enable held
        en = 1'b1; mask = 4'b1111;
        run_to_starts(5, 400, "full_timeout");
        repeat (40) step();
        for (int i = 0; i < 5; i++) check("full_id_seq", bs_ids[i], i % 4);
        check("full_bs_spacing", bs_cyc[1] - bs_cyc[0], 40);
        check("full_bs_spacing2", bs_cyc[4] - bs_cyc[3], 40);
        check("full_fs_spacing", fs_cyc[1] - fs_cyc[0], 160);
        check("full_hi_ch0", hi_cnt[0], 16);
        check("full_hi_ch1", hi_cnt[1], 8);
        check("full_hi_ch3", hi_cnt[3], 8);

        // Sparse mask 1010
        do_reset();
        en = 1'b1; mask = 4'b1010;
        run_to_starts(4, 300, "sparse_timeout");
        for (int i = 0; i < 4; i++) check("sparse_id_seq", bs_ids[i], (i % 2 == 0) ? 1 : 3);
        check("sparse_hi_ch0", hi_cnt[0], 0);
        check("sparse_hi_ch2", hi_cnt[2], 0);

        // Mask changes mid-slot
        do_reset();
        en = 1'b1; mask = 4'b0001;
        run_to_offset(20, 100, "maskchg_reach");
        mask = 4'b0100;
        run_to_starts(2, 100, "maskchg_timeout");
        check("maskchg_first", bs_ids[0], 0);
        check("maskchg_second", bs_ids[1], 2);

        // ENABLE dropped during the first burst period
        do_reset();
        en = 1'b1; mask = 4'b1111;
        run_to_offset(2, 100, "burstdrop_reach");
        en = 1'b0;
        repeat (60) step();
        check("burstdrop_starts", bs_ids.size(), 1);
        check("burstdrop_hi", hi_cnt[0], 2 * 4);
        check("burstdrop_sv", sv_cnt, BP * DIV);

        // ENABLE dropped during LISTEN
        do_reset();
        en = 1'b1; mask = 4'b1111;
        run_to_offset(25, 100, "listendrop_reach");
        en = 1'b0;
        clear_stats();
        repeat (60) step();
        check("listendrop_starts", bs_ids.size(), 0);
        check("listendrop_sv", sv_cnt, 1);

        // RST mid-burst, then an empty mask
        en = 1'b1; mask = 4'b0110;
        run_to_offset(5, 100, "rstburst_reach");
        do_reset();
        en = 1'b1; mask = 4'b0000;
        repeat (100) step();
        check("zeromask_starts", bs_ids.size(), 0);

        // Random traffic
        for (int it = 0; it < 40; it++) begin
            mask = 4'($urandom_range(0, 15));
            en   = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 60)) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
